send_top: RTL and testbench

Ethernet-style frame transmitter: serializes one frame per request onto a byte-wide line, one byte per cycle. It emits the preamble, SFD, destination and source MAC, length field and payload, then a 4-byte FCS. Payload bytes are pulled from a producer through a valid/ready handshake. It is the transmit counterpart of the frame receiver and uses the same frame layout and the same 8-bit LRC check.

---
 rtl/send_top.sv | 187 ++++++++++++++++++
 tb/tb_send_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/send_top.sv
// send_top: byte-wide Ethernet-style frame transmitter with an 8-bit LRC FCS.
// Optional zero padding of short payloads up to MIN_PL bytes: define SEND_PAD_EN.
module send_top #(
    parameter logic [47:0] SRC_MAC_ADDR = 48'h00_0a_95_9d_68_20,
    parameter int unsigned MIN_PL       = 46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dest_mac,
    input  logic [15:0] pl_len,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        ready,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, MACDST, MACSRC, PLLEN, PL, PAD, FCS, DONE, ERROR
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_len;
    logic [47:0] r_dst;
    logic [47:0] r_src;
    logic [7:0]  r_lrc;
    logic [7:0]  r_tx_data;
    logic        r_tx_en;
    logic        r_done;
    logic        r_err;

    logic        w_pl_more;
    logic        w_in_rdy;
    logic        w_need_pad;
    logic        w_pad_more;
    logic [7:0]  w_fcs;

    assign w_pl_more = ({1'b0, r_cnt} + 17'd1) < {1'b0, r_len};
    assign w_in_rdy  = (r_state == PLLEN && r_cnt == 16'd1 && r_len != '0) ||
                       (r_state == PL && w_pl_more);
    assign w_fcs     = ~r_lrc + 8'd1;

`ifdef SEND_PAD_EN
    assign w_need_pad = 32'(r_len) < MIN_PL;
    assign w_pad_more = (32'(r_cnt) + 32'(r_len) + 32'd1) < MIN_PL;
`else
    assign w_need_pad = 1'b0;
    assign w_pad_more = 1'b0;
`endif

    assign in_rdy  = w_in_rdy;
    assign tx_data = r_tx_data;
    assign tx_en   = r_tx_en;
    assign done    = r_done;
    assign err     = r_err;
    assign ready   = (r_state == IDLE) && !rst;

    // tx_data/tx_en are loaded on the edge that enters each byte position,
    // so the registered byte always belongs to the current state/count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_dst     <= '0;
            r_src     <= '0;
            r_lrc     <= '0;
            r_tx_data <= '0;
            r_tx_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_lrc <= '0;
                    r_cnt <= '0;
                    if (start) begin
                        r_dst     <= dest_mac;
                        r_src     <= SRC_MAC_ADDR;
                        r_len     <= pl_len;
                        r_state   <= PREAMBLE;
                        r_tx_en   <= 1'b1;
                        r_tx_data <= 8'h55;
                    end
                end
                PREAMBLE: begin
                    if (r_cnt == 16'd6) begin
                        r_state   <= SFD;
                        r_cnt     <= '0;
                        r_tx_data <= 8'hD5;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                SFD: begin
                    r_state   <= MACDST;
                    r_tx_data <= r_dst[7:0];
                    r_lrc     <= r_lrc + r_dst[7:0];
                    r_dst     <= r_dst >> 8;
                end
                MACDST: begin
                    if (r_cnt == 16'd5) begin
                        r_state   <= MACSRC;
                        r_cnt     <= '0;
                        r_tx_data <= r_src[7:0];
                        r_lrc     <= r_lrc + r_src[7:0];
                        r_src     <= r_src >> 8;
                    end else begin
                        r_cnt     <= r_cnt + 16'd1;
                        r_tx_data <= r_dst[7:0];
                        r_lrc     <= r_lrc + r_dst[7:0];
                        r_dst     <= r_dst >> 8;
                    end
                end
                MACSRC: begin
                    if (r_cnt == 16'd5) begin
                        r_state   <= PLLEN;
                        r_cnt     <= '0;
                        r_tx_data <= r_len[15:8];
                        r_lrc     <= r_lrc + r_len[15:8];
                    end else begin
                        r_cnt     <= r_cnt + 16'd1;
                        r_tx_data <= r_src[7:0];
                        r_lrc     <= r_lrc + r_src[7:0];
                        r_src     <= r_src >> 8;
                    end
                end
                PLLEN, PL: begin
                    if (r_state == PLLEN && r_cnt == 16'd0) begin
                        r_cnt     <= 16'd1;
                        r_tx_data <= r_len[7:0];
                        r_lrc     <= r_lrc + r_len[7:0];
                    end else if (w_in_rdy && !in_vld) begin
                        r_state   <= ERROR;
                        r_tx_en   <= 1'b0;
                        r_tx_data <= '0;
                        r_err     <= 1'b1;
                    end else if (w_in_rdy) begin
                        r_state   <= PL;
                        r_cnt     <= (r_state == PL) ? r_cnt + 16'd1 : 16'd0;
                        r_tx_data <= in_data;
                        r_lrc     <= r_lrc + in_data;
                    end else if (w_need_pad) begin
                        r_state   <= PAD;
                        r_cnt     <= '0;
                        r_tx_data <= '0;
                    end else begin
                        r_state   <= FCS;
                        r_cnt     <= '0;
                        r_tx_data <= w_fcs;
                    end
                end
                PAD: begin
                    if (w_pad_more) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_state   <= FCS;
                        r_cnt     <= '0;
                        r_tx_data <= w_fcs;
                    end
                end
                FCS: begin
                    if (r_cnt == 16'd3) begin
                        r_state   <= DONE;
                        r_cnt     <= '0;
                        r_tx_en   <= 1'b0;
                        r_tx_data <= '0;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_tx_en   <= 1'b0;
                    r_tx_data <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_send_top.sv
// Self-checking bench for send_top: table of frames with hand-computed FCS,
// plus reset-mid-frame and back-to-back sequences.
module tb_send_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] dest_mac;
    logic [15:0] pl_len;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        ready;
    logic        done;
    logic        err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [47:0] SRC_MAC = 48'h000a959d6820;
    localparam int          MIN_PL  = 46;

    send_top dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dest_mac (dest_mac),
        .pl_len   (pl_len),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .ready    (ready),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [47:0] dest;
        logic [7:0]  base;
        int          drop;
        logic [7:0]  fcs;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pl_total(input int len);
`ifdef SEND_PAD_EN
        return (len < MIN_PL) ? MIN_PL : len;
`else
        return len;
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input vec_t v, input int pos);
        logic [47:0] d;
        logic [47:0] s;
        int p;
        d = v.dest;
        s = SRC_MAC;
        p = pos - 22;
        if (pos < 7)  return 8'h55;
        if (pos == 7) return 8'hD5;
        if (pos < 14) return d[8*(pos-8) +: 8];
        if (pos < 20) return s[8*(pos-14) +: 8];
        if (pos == 20) return v.len[15:8];
        if (pos == 21) return v.len[7:0];
        if (p < int'(v.len)) return v.base + 8'(p);
        if (p < pl_total(int'(v.len))) return 8'h00;
        return v.fcs;
    endfunction

    task automatic wait_ready();
        int cyc = 0;
        while (!ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_wait", ready, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int  pos = 0;
        int  p = 0;
        int  rdy_cnt = 0;
        int  cyc = 0;
        bit  fin = 0;
        bit  acc = 0;
        bit  got_err = 0;
        wait_ready();
        start    = 1'b1;
        dest_mac = v.dest;
        pl_len   = v.len;
        in_vld   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 1000) begin
            if (acc) p++;
            if (tx_en) begin
                check("tx_byte", tx_data, exp_byte(v, pos));
                pos++;
            end else if (done) begin
                fin = 1;
            end else if (err) begin
                fin = 1;
                got_err = 1;
            end else begin
                check("tx_en_drop", tx_en, 1);
                fin = 1;
            end
            in_data = v.base + 8'(p);
            in_vld  = (p != v.drop);
            if (in_rdy) rdy_cnt++;
            acc = in_rdy && in_vld;
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        in_vld = 1'b0;
        check("frame_ended", fin, 1);
        check("end_is_err", got_err, v.drop >= 0);
        check("end_tx_data", tx_data, 0);
        check("end_ready", ready, 0);
        if (v.drop < 0) begin
            check("frame_len", pos, 26 + pl_total(int'(v.len)));
            check("in_rdy_count", rdy_cnt, v.len);
        end else begin
            check("trunc_len", pos, 22 + v.drop);
        end
        @(negedge clk);
        check("post_ready", ready, 1);
        check("post_done", done, 0);
        check("post_err", err, 0);
    endtask

    initial begin
        int n1;
        int gap;
        int cyc;
        vecs[0] = '{16'd1, 48'h000a959d6816, 8'h01, -1, 8'h80};
        vecs[1] = '{16'd0, 48'h000a959d6816, 8'h00, -1, 8'h82};
        vecs[2] = '{16'd4, 48'h000a959d6816, 8'h10, -1, 8'h38};
        vecs[3] = '{16'd4, 48'h000a959d6816, 8'h10,  2, 8'h00};
        vecs[4] = '{16'd3, 48'h112233445566, 8'hF0, -1, 8'h01};

        rst = 1'b1;
        start = 1'b1;
        dest_mac = '0;
        pl_len = '0;
        in_data = '0;
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", ready, 0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset while MACSRC bytes are on the line
        wait_ready();
        start = 1'b1;
        dest_mac = vecs[0].dest;
        pl_len = vecs[0].len;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_pre_en", tx_en, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_en", tx_en, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_ready", ready, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0]);

        // start held high across a whole frame
        wait_ready();
        start = 1'b1;
        dest_mac = vecs[1].dest;
        pl_len = 16'd0;
        @(negedge clk);
        n1 = 0;
        while (tx_en && n1 < 200) begin
            n1++;
            @(negedge clk);
        end
        gap = 0;
        while (!tx_en && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_len", n1, 26 + pl_total(0));
        check("b2b_gap", gap, 2);
        check("b2b_first", tx_data, 8'h55);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_done", done, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
